hazard_sequencer: RTL and testbench

- Pipeline hazard controller for the 5-stage 64-bit pipelined CPU.
- Drives the enable, flush and bubble controls of the PC register, the IF/ID register bank, and the ID/EX and EX/MEM pipeline registers.
- Sequences three events:
  - load-use stalls;
  - taken-branch redirects with a configurable squash window;
  - whole-pipe freezes while data memory is busy.

---
 rtl/hazard_sequencer.sv | 175 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stalls, taken-branch squash window, data-memory freeze.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters; otherwise they read 0.
module hazard_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned ZERO_REG     = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_br_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [3:0] FCNT_INIT   = 4'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [7:0] MCNT_LIMIT  = 8'(MEM_TIMEOUT);
  localparam logic [4:0] ZREG        = 5'(ZERO_REG);

  logic [1:0] state_q, state_d, eff_state;
  logic [3:0] fcnt_q, fcnt_d;
  logic [7:0] mcnt_q, mcnt_d;
  logic       ret_redirect_q, ret_redirect_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic lu;
  logic pc_en_c, pc_redirect_c, ifid_en_c, ifid_flush_c, idex_bubble_c, exmem_en_c;

  assign lu = ex_memread && (ex_rd != ZREG) &&
              ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    mcnt_d         = mcnt_q;
    ret_redirect_d = ret_redirect_q;
    pc_en_c        = 1'b0;
    pc_redirect_c  = 1'b0;
    ifid_en_c      = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_en_c     = 1'b0;
    eff_state      = state_q;

    // Leaving MEM_WAIT: this cycle is handled as the state we return to.
    if (state_q == ST_MEM_WAIT) begin
      if (mem_busy) begin
        mcnt_d = (mcnt_q == 8'hFF) ? mcnt_q : mcnt_q + 8'd1;
      end else begin
        mcnt_d    = '0;
        eff_state = ret_redirect_q ? ST_REDIRECT : ST_RUN;
      end
    end

    case (eff_state)
      ST_RUN: begin
        if (mem_busy) begin
          ret_redirect_d = 1'b0;
          mcnt_d         = 8'd1;
          state_d        = ST_MEM_WAIT;
        end else if (ex_br_taken) begin
          pc_redirect_c = 1'b1;
          pc_en_c       = 1'b1;
          ifid_en_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_en_c    = 1'b1;
          fcnt_d        = FCNT_INIT;
          state_d       = MULTI_FLUSH ? ST_REDIRECT : ST_RUN;
        end else if (lu) begin
          idex_bubble_c = 1'b1;
          exmem_en_c    = 1'b1;
          state_d       = ST_RUN;
        end else begin
          pc_en_c    = 1'b1;
          ifid_en_c  = 1'b1;
          exmem_en_c = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (mem_busy) begin
          ret_redirect_d = 1'b1;
          mcnt_d         = 8'd1;
          state_d        = ST_MEM_WAIT;
        end else begin
          pc_en_c       = 1'b1;
          ifid_en_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_en_c    = 1'b1;
          fcnt_d        = fcnt_q - 4'd1;
          state_d       = (fcnt_d == 4'd0) ? ST_RUN : ST_REDIRECT;
        end
      end
      default: begin
        state_d = ST_MEM_WAIT;
      end
    endcase

    mem_timeout_d = mem_timeout_q || (mcnt_d >= MCNT_LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      fcnt_q         <= '0;
      mcnt_q         <= '0;
      ret_redirect_q <= 1'b0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      mcnt_q         <= mcnt_d;
      ret_redirect_q <= ret_redirect_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  // Reset forces a safe hold: nothing advances and both pipeline bubbles are injected.
  assign pc_en       = rst & pc_en_c;
  assign pc_redirect = rst & pc_redirect_c;
  assign ifid_en     = rst & ifid_en_c;
  assign exmem_en    = rst & exmem_en_c;
  assign ifid_flush  = ~rst | ifid_flush_c;
  assign idex_bubble = ~rst | idex_bubble_c;
  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Vector-table and sequence bench for hazard_sequencer (FLUSH_CYCLES=3, MEM_TIMEOUT=4).
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rn = '0, id_rm = '0, ex_rd = '0;
  logic        id_uses_rn = 1'b0, id_uses_rm = 1'b0, ex_memread = 1'b0;
  logic        ex_br_taken = 1'b0, mem_busy = 1'b0;
  logic        pc_en, pc_redirect, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_sequencer #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .ZERO_REG(31)) dut (
    .clk(clk), .rst(rst),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Expected output vectors: {pc_en, pc_redirect, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_timeout}
  localparam logic [6:0] O_RUN   = 7'b1010010;
  localparam logic [6:0] O_STALL = 7'b0000110;
  localparam logic [6:0] O_BR    = 7'b1111110;
  localparam logic [6:0] O_REDIR = 7'b1011110;
  localparam logic [6:0] O_FRZ   = 7'b0000000;
  localparam logic [6:0] O_RST   = 7'b0001100;

  typedef struct {
    string      name;
    logic [4:0] rn;
    logic       urn;
    logic [4:0] rm;
    logic       urm;
    logic       memrd;
    logic [4:0] rd;
    logic       br;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[11];

  function automatic vec_t mk(input string n, input logic [4:0] rn, input logic urn,
                              input logic [4:0] rm, input logic urm, input logic memrd,
                              input logic [4:0] rd, input logic br, input logic busy,
                              input logic [6:0] exp);
    vec_t v;
    v.name = n; v.rn = rn; v.urn = urn; v.rm = rm; v.urm = urm;
    v.memrd = memrd; v.rd = rd; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t idle(input string n, input logic [6:0] exp);
    return mk(n, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp);
  endfunction

  function automatic vec_t busy(input string n, input logic [6:0] exp);
    return mk(n, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, exp);
  endfunction

  function automatic vec_t branch(input string n, input logic [6:0] exp);
    return mk(n, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, exp);
  endfunction

  task automatic compare_front();
    exp_t       e;
    logic [6:0] act;
    e   = exp_q.pop_front();
    act = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_timeout};
    n_tests++;
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    id_rn = v.rn; id_uses_rn = v.urn; id_rm = v.rm; id_uses_rm = v.urm;
    ex_memread = v.memrd; ex_rd = v.rd; ex_br_taken = v.br; mem_busy = v.busy;
    exp_q.push_back('{name: v.name, exp: v.exp});
    #2;
    compare_front();
  endtask

  task automatic check_now(input string n, input logic [6:0] exp);
    exp_q.push_back('{name: n, exp: exp});
    compare_front();
  endtask

  task automatic check_cnt(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rn = '0; id_rm = '0; ex_rd = '0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_memread = 1'b0;
    ex_br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset(input string n);
    @(negedge clk);
    #1 rst = 1'b0;
    clear_inputs();
    #1 check_now(n, O_RST);
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = idle("idle", O_RUN);
    tbl[1]  = mk("lu_rn", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, O_STALL);
    tbl[2]  = idle("after_lu", O_RUN);
    tbl[3]  = mk("lu_rm", 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, O_STALL);
    tbl[4]  = mk("xzr", 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, O_RUN);
    tbl[5]  = mk("rn_unused", 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, O_RUN);
    tbl[6]  = mk("not_load", 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, O_RUN);
    tbl[7]  = mk("br_and_lu", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, O_BR);
    tbl[8]  = mk("redir_ign", 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, O_REDIR);
    tbl[9]  = idle("redir_last", O_REDIR);
    tbl[10] = idle("back_to_run", O_RUN);

    clear_inputs();
    #3 check_now("reset_outputs", O_RST);
    check_cnt("reset_stall_cnt", stall_cnt, 32'd0);
    check_cnt("reset_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    for (int unsigned i = 0; i < 11; i++) step(tbl[i]);

    // Perf counters over one branch window and one load-use stall.
    do_reset("reset_before_cnt");
    step(branch("cnt_br", O_BR));
    step(idle("cnt_redir1", O_REDIR));
    step(idle("cnt_redir2", O_REDIR));
    step(idle("cnt_run", O_RUN));
    step(mk("cnt_lu", 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, O_STALL));
    step(idle("cnt_run2", O_RUN));
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("flush_cnt", flush_cnt, 32'd3);
    check_cnt("stall_cnt", stall_cnt, 32'd1);
`else
    check_cnt("flush_cnt_tied", flush_cnt, 32'd0);
    check_cnt("stall_cnt_tied", stall_cnt, 32'd0);
`endif

    // Reset during a redirect leaves no pending squash.
    do_reset("reset_pre_redir");
    step(branch("rst_br", O_BR));
    do_reset("reset_mid_redir");
    step(idle("no_redir_after_rst", O_RUN));

    // mem_busy for 4 cycles in REDIRECT with one flush cycle left.
    step(branch("mb_br", O_BR));
    step(idle("mb_redir1", O_REDIR));
    for (int unsigned i = 0; i < 4; i++) step(busy("mb_freeze", O_FRZ));
    step(idle("mb_last_flush", O_REDIR | 7'b0000001));
    step(idle("mb_run", O_RUN | 7'b0000001));

    // Watchdog: MEM_TIMEOUT=4 sets after MEM_WAIT entry plus three increments.
    do_reset("reset_before_to");
    step(idle("to_idle", O_RUN));
    for (int unsigned i = 0; i < 4; i++) step(busy("to_pre", O_FRZ));
    for (int unsigned i = 0; i < 6; i++) step(busy("to_set", O_FRZ | 7'b0000001));
    step(mk("to_exit_lu", 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, O_STALL | 7'b0000001));
    step(idle("to_sticky", O_RUN | 7'b0000001));
    step(busy("to_busy_again", O_FRZ | 7'b0000001));
    @(posedge clk);
    #3 rst = 1'b0;
    clear_inputs();
    #1 check_now("async_reset", O_RST);
    @(negedge clk);
    #1 rst = 1'b1;
    step(idle("after_async_reset", O_RUN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
